// File: rtl/xsw_pkg.sv
// Shared types for the crossbar LUT reconfiguration block: FSM state encoding
// and the identity-LUT helper used as the reset routing.
package xsw_pkg;

   localparam int XSW_MAX_M     = 16;
   localparam int XSW_MAX_LUT_W = XSW_MAX_M * XSW_MAX_M;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_UPDATE = 2'd2
   } xsw_cfg_st_e;

   // Row d routes to output d; bits above m*m stay zero so callers can slice.
   function automatic logic [XSW_MAX_LUT_W-1:0] xsw_identity_lut(input int m);
      logic [XSW_MAX_LUT_W-1:0] id_lut;
      id_lut = '0;
      for (int d = 0; d < XSW_MAX_M; d++) begin
         if (d < m) begin
            id_lut = id_lut | (XSW_MAX_LUT_W'(1) << (d * m + d));
         end
      end
      return id_lut;
   endfunction

endpackage

// File: rtl/xsw_onehot_chk.sv
// One-hot detector for a single LUT row; true when exactly one bit is set.
module xsw_onehot_chk #(
   parameter int W = 3
) (
   input  logic [W-1:0] row,
   output logic         onehot
);

   always_comb begin
      onehot = (row != '0) && ((row & (row - W'(1))) == '0);
   end

endmodule

// File: rtl/xsw_lut_cfg.sv
// Safe runtime LUT swap for the crossbar: drains agents, then loads a new LUT.
// Optional drain timeout is enabled with the XSW_CFG_TIMEOUT_EN macro.
module xsw_lut_cfg
   import xsw_pkg::*;
#(
   parameter int N      = 2,
   parameter int M      = 3,
   parameter int TO_CYC = 255
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           cfg_vld,
   input  logic [M*M-1:0] cfg_lut,
   output logic           cfg_gnt,
   output logic           cfg_err,
   output logic           busy,
   input  logic [N-1:0]   vld_a,
   input  logic [N-1:0]   gnt_a,
   input  logic [N-1:0]   ocy_a,
   input  logic [N-1:0]   rel_a,
   output logic [N-1:0]   vld_sw,
   output logic [M*M-1:0] lut
);

   localparam logic [XSW_MAX_LUT_W-1:0] ID_FULL = xsw_identity_lut(M);
   localparam logic [M*M-1:0]           ID_LUT  = ID_FULL[M*M-1:0];

   if (M > XSW_MAX_M || M < 1 || TO_CYC < 1) begin : g_param_err
      $error("xsw_lut_cfg: unsupported M or TO_CYC");
   end

   xsw_cfg_st_e    st_q, st_d;
   logic [N-1:0]   lck_q, lck_d;
   logic [N-1:0]   blk_q, blk_d;
   logic [M*M-1:0] stg_q, stg_d;
   logic [M*M-1:0] lut_q, lut_d;
   logic [M-1:0]   row_ok;
   logic [N-1:0]   xfer;
   logic [N-1:0]   drain_set;
   logic           gnt_c, err_c;
   logic           to_hit;

   for (genvar d = 0; d < M; d++) begin : g_row_chk
      xsw_onehot_chk #(.W(M)) u_chk (
         .row    (cfg_lut[d*M +: M]),
         .onehot (row_ok[d])
      );
   end

   // A locked agent may only be blocked once its release beat has been accepted.
   always_comb begin
      xfer      = vld_a & gnt_a;
      lck_d     = (lck_q | (xfer & ocy_a)) & ~(xfer & rel_a);
      drain_set = (~vld_a | gnt_a) & ~lck_d;
   end

`ifdef XSW_CFG_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      to_hit = (st_q == ST_DRAIN) && (cnt_q == CW'(TO_CYC - 1));
      cnt_d  = '0;
      if (st_q == ST_DRAIN && st_d == ST_DRAIN) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   always_comb begin
      to_hit = 1'b0;
   end
`endif

   always_comb begin
      st_d  = st_q;
      blk_d = blk_q;
      stg_d = stg_q;
      lut_d = lut_q;
      gnt_c = 1'b0;
      err_c = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (cfg_vld) begin
               if (&row_ok) begin
                  stg_d = cfg_lut;
                  st_d  = ST_DRAIN;
               end else begin
                  gnt_c = 1'b1;
                  err_c = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            blk_d = blk_q | drain_set;
            if (&blk_d) begin
               st_d = ST_UPDATE;
            end else if (to_hit) begin
               gnt_c = 1'b1;
               err_c = 1'b1;
               blk_d = '0;
               st_d  = ST_IDLE;
            end
         end
         ST_UPDATE: begin
            gnt_c = 1'b1;
            lut_d = stg_q;
            blk_d = '0;
            st_d  = ST_IDLE;
         end
         default: begin
            blk_d = '0;
            st_d  = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q  <= ST_IDLE;
         lck_q <= '0;
         blk_q <= '0;
         stg_q <= '0;
         lut_q <= ID_LUT;
      end else begin
         st_q  <= st_d;
         lck_q <= lck_d;
         blk_q <= blk_d;
         stg_q <= stg_d;
         lut_q <= lut_d;
      end
   end

   // Pulses are combinational, so hold them off while reset is asserted.
   always_comb begin
      cfg_gnt = gnt_c & rstn;
      cfg_err = err_c & rstn;
      busy    = (st_q != ST_IDLE);
      vld_sw  = vld_a & ~blk_q;
      lut     = lut_q;
   end

endmodule

// File: tb/tb_xsw_lut_cfg.sv
// Self-checking bench for xsw_lut_cfg: directed scenarios followed by random
// traffic and requests, all checked against a cycle-level behavioural model.
module tb_xsw_lut_cfg;

   localparam int N  = 2;
   localparam int M  = 3;
   localparam int TO = 4;
   localparam int LW = M * M;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cfg_vld;
   logic [LW-1:0] cfg_lut;
   logic          cfg_gnt, cfg_err, busy;
   logic [N-1:0]  vld_a, gnt_a, ocy_a, rel_a;
   logic [N-1:0]  vld_sw;
   logic [LW-1:0] lut;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   xsw_lut_cfg #(.N(N), .M(M), .TO_CYC(TO)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .cfg_vld (cfg_vld),
      .cfg_lut (cfg_lut),
      .cfg_gnt (cfg_gnt),
      .cfg_err (cfg_err),
      .busy    (busy),
      .vld_a   (vld_a),
      .gnt_a   (gnt_a),
      .ocy_a   (ocy_a),
      .rel_a   (rel_a),
      .vld_sw  (vld_sw),
      .lut     (lut)
   );

   // Reference model state: phase flags, per-agent lock/block bits, LUTs.
   bit            m_drain, m_update;
   bit  [N-1:0]   m_lck, m_blk;
   logic [LW-1:0] m_lut, m_stage;
   int            m_dcyc;

   bit            n_drain, n_update;
   bit  [N-1:0]   n_lck, n_blk;
   logic [LW-1:0] n_lut, n_stage;
   int            n_dcyc;

   logic [N-1:0]  e_vsw;
   logic [LW-1:0] e_lut;
   logic          e_gnt, e_err, e_busy;

   function automatic logic [LW-1:0] ident_lut();
      logic [LW-1:0] r;
      r = '0;
      for (int d = 0; d < M; d++) r = r | (LW'(1) << (d * M + d));
      return r;
   endfunction

   function automatic bit rows_onehot(input logic [LW-1:0] v);
      logic [M-1:0] row;
      for (int d = 0; d < M; d++) begin
         row = M'(v >> (d * M));
         if ($countones(row) != 1) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_drain  = 1'b0;
      m_update = 1'b0;
      m_lck    = '0;
      m_blk    = '0;
      m_lut    = ident_lut();
      m_stage  = '0;
      m_dcyc   = 0;
   endtask

   // Expected outputs for the current cycle plus the state after the next edge.
   task automatic model_eval();
      e_vsw  = vld_a & ~m_blk;
      e_busy = m_drain | m_update;
      e_lut  = m_lut;
      e_gnt  = 1'b0;
      e_err  = 1'b0;
      n_drain = m_drain; n_update = m_update; n_blk = m_blk;
      n_lut = m_lut; n_stage = m_stage; n_dcyc = m_dcyc;
      for (int i = 0; i < N; i++) begin
         n_lck[i] = m_lck[i];
         if (vld_a[i] && gnt_a[i]) begin
            if (rel_a[i])      n_lck[i] = 1'b0;
            else if (ocy_a[i]) n_lck[i] = 1'b1;
         end
      end
      if (m_update) begin
         e_gnt    = 1'b1;
         n_lut    = m_stage;
         n_blk    = '0;
         n_update = 1'b0;
      end else if (m_drain) begin
         for (int i = 0; i < N; i++) begin
            if ((!vld_a[i] || gnt_a[i]) && !n_lck[i]) n_blk[i] = 1'b1;
         end
         if (n_blk == {N{1'b1}}) begin
            n_drain  = 1'b0;
            n_update = 1'b1;
         end else begin
`ifdef XSW_CFG_TIMEOUT_EN
            if (m_dcyc == TO) begin
               e_gnt   = 1'b1;
               e_err   = 1'b1;
               n_blk   = '0;
               n_drain = 1'b0;
            end else begin
               n_dcyc = m_dcyc + 1;
            end
`endif
         end
      end else if (cfg_vld) begin
         if (rows_onehot(cfg_lut)) begin
            n_stage = cfg_lut;
            n_drain = 1'b1;
            n_dcyc  = 1;
         end else begin
            e_gnt = 1'b1;
            e_err = 1'b1;
         end
      end
      if (!rstn) begin
         e_gnt = 1'b0;
         e_err = 1'b0;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Settle inputs, then compare every output against the model.
   task automatic apply_stimulus(input string tag);
      #1;
      if (!rstn) model_reset();
      model_eval();
      check_output({tag, ".vld_sw"},  32'(vld_sw),  32'(e_vsw));
      check_output({tag, ".lut"},     32'(lut),     32'(e_lut));
      check_output({tag, ".cfg_gnt"}, 32'(cfg_gnt), 32'(e_gnt));
      check_output({tag, ".cfg_err"}, 32'(cfg_err), 32'(e_err));
      check_output({tag, ".busy"},    32'(busy),    32'(e_busy));
   endtask

   task automatic advance();
      @(posedge clk);
      if (rstn) begin
         m_drain = n_drain; m_update = n_update; m_lck = n_lck; m_blk = n_blk;
         m_lut = n_lut; m_stage = n_stage; m_dcyc = n_dcyc;
      end else begin
         model_reset();
      end
      @(negedge clk);
   endtask

   task automatic cycle(input string tag);
      apply_stimulus(tag);
      advance();
   endtask

   task automatic set_traffic(input logic [N-1:0] v, g, o, r);
      vld_a = v; gnt_a = g; ocy_a = o; rel_a = r;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      cycle("rst");
      rstn = 1'b1;
   endtask

   bit req_pend;

   initial begin
      rstn    = 1'b0;
      cfg_vld = 1'b0;
      cfg_lut = '0;
      set_traffic('0, '0, '0, '0);
      model_reset();
      @(negedge clk);
      cycle("rst0");
      check_output("rst0.lut_id", 32'(lut), 32'(9'b100_010_001));
      rstn = 1'b1;

      // Valid request with no traffic: accept, one DRAIN cycle, UPDATE.
      cfg_vld = 1'b1; cfg_lut = 9'b001_100_010;
      cycle("v.c1");
      cycle("v.c2");
      apply_stimulus("v.c3");
      check_output("v.c3.gnt_third", 32'(cfg_gnt), 32'd1);
      advance();
      cfg_vld = 1'b0;
      apply_stimulus("v.c4");
      check_output("v.c4.new_lut", 32'(lut), 32'(9'b001_100_010));
      advance();

      // Invalid request: row 1 has two bits set.
      do_reset();
      cfg_vld = 1'b1; cfg_lut = {3'b100, 3'b011, 3'b001};
      apply_stimulus("inv");
      check_output("inv.gnt", 32'(cfg_gnt), 32'd1);
      check_output("inv.err", 32'(cfg_err), 32'd1);
      advance();
      cfg_vld = 1'b0;
      apply_stimulus("inv.after");
      check_output("inv.lut_kept", 32'(lut), 32'(9'b100_010_001));
      check_output("inv.busy", 32'(busy), 32'd0);
      advance();

      // Locked agent 0 must finish before the swap; agent 1 gets gated.
      set_traffic(2'b01, 2'b01, 2'b01, 2'b00);
      cycle("lk.lock");
      cfg_vld = 1'b1; cfg_lut = 9'b010_001_100;
      cycle("lk.acc");
      cycle("lk.d1");
      set_traffic(2'b11, 2'b01, 2'b01, 2'b00);
      apply_stimulus("lk.d2");
      check_output("lk.d2.gate1", 32'(vld_sw), 32'(2'b01));
      advance();
      set_traffic(2'b11, 2'b01, 2'b00, 2'b01);
      apply_stimulus("lk.rel");
      check_output("lk.rel.nognt", 32'(cfg_gnt), 32'd0);
      advance();
      set_traffic(2'b00, 2'b00, 2'b00, 2'b00);
      apply_stimulus("lk.upd");
      check_output("lk.upd.gnt", 32'(cfg_gnt), 32'd1);
      advance();
      cfg_vld = 1'b0;
      apply_stimulus("lk.idle");
      check_output("lk.idle.lut", 32'(lut), 32'(9'b010_001_100));
      advance();

      // Pending ungranted request stays visible until granted.
      set_traffic(2'b10, 2'b00, 2'b00, 2'b00);
      cfg_vld = 1'b1; cfg_lut = 9'b100_010_001;
      cycle("pd.acc");
      apply_stimulus("pd.d1");
      check_output("pd.d1.pending", 32'(vld_sw), 32'(2'b10));
      advance();
      gnt_a = 2'b10;
      apply_stimulus("pd.d2");
      check_output("pd.d2.still", 32'(vld_sw), 32'(2'b10));
      advance();
      gnt_a = 2'b00;
      apply_stimulus("pd.upd");
      check_output("pd.upd.gated", 32'(vld_sw), 32'(2'b00));
      advance();
      cfg_vld = 1'b0;
      apply_stimulus("pd.idle");
      check_output("pd.idle.open", 32'(vld_sw), 32'(2'b10));
      advance();

      // Reset in the middle of a drain aborts silently.
      set_traffic(2'b01, 2'b01, 2'b01, 2'b00);
      cycle("rd.lock");
      set_traffic(2'b00, 2'b00, 2'b00, 2'b00);
      cfg_vld = 1'b1; cfg_lut = 9'b001_010_100;
      cycle("rd.acc");
      cycle("rd.d1");
      rstn = 1'b0;
      apply_stimulus("rd.rst");
      check_output("rd.rst.busy", 32'(busy), 32'd0);
      check_output("rd.rst.lut", 32'(lut), 32'(9'b100_010_001));
      advance();
      rstn = 1'b1; cfg_vld = 1'b0;
      vld_a = 2'b11;
      apply_stimulus("rd.after");
      check_output("rd.after.blk", 32'(vld_sw), 32'(2'b11));
      advance();

`ifdef XSW_CFG_TIMEOUT_EN
      // Agent 0 never releases: the drain gives up on its TO-th cycle.
      set_traffic(2'b01, 2'b01, 2'b01, 2'b00);
      cycle("to.lock");
      set_traffic(2'b00, 2'b00, 2'b00, 2'b00);
      cfg_vld = 1'b1; cfg_lut = 9'b010_100_001;
      cycle("to.acc");
      for (int k = 1; k < TO; k++) cycle("to.drain");
      apply_stimulus("to.last");
      check_output("to.err", 32'(cfg_err), 32'd1);
      advance();
      cfg_vld = 1'b0;
      vld_a = 2'b10;
      apply_stimulus("to.after");
      check_output("to.ungate", 32'(vld_sw), 32'(2'b10));
      check_output("to.lut", 32'(lut), 32'(9'b100_010_001));
      advance();
      gnt_a = 2'b01; vld_a = 2'b01; rel_a = 2'b01;
      cycle("to.unlock");
`endif

      // Random traffic and requests; cfg_vld is held until the model grants.
      req_pend = 1'b0;
      cfg_vld  = 1'b0;
      for (int c = 0; c < 400; c++) begin
         vld_a = N'($urandom);
         gnt_a = N'($urandom);
         ocy_a = N'($urandom);
         rel_a = N'($urandom);
         if (!req_pend && $urandom_range(7) == 0) begin
            req_pend = 1'b1;
            cfg_vld  = 1'b1;
            if ($urandom_range(9) < 7) begin
               for (int d = 0; d < M; d++) begin
                  cfg_lut[d*M +: M] = M'(1) << $urandom_range(M - 1);
               end
            end else begin
               cfg_lut = LW'($urandom);
            end
         end
         apply_stimulus("rnd");
         if (req_pend && e_gnt) begin
            req_pend = 1'b0;
         end
         advance();
         if (!req_pend) cfg_vld = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
